// File: rtl/ad2tx_framer.sv
// ad2tx_framer: reads a payload from the ADC-to-TX sample buffer and emits
// the framed stream A5 5A LEN_HI LEN_LO <payload> <checksum> to the TX
// serializer. Buffer read latency is absorbed by a small skid FIFO whose
// occupancy plus in-flight reads never exceeds its depth.
module ad2tx_framer #(
    parameter int AW     = 11,
    parameter int DW     = 8,
    parameter int RD_LAT = 2,
    parameter int FIFO_D = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW-1:0] frame_len,
    output logic          busy,
    output logic          done,
    output logic          rd_ce,
    output logic          rd_oce,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic [DW-1:0] tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic          tx_last
);

    localparam int PW = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
    localparam int CW = $clog2(FIFO_D + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR,
        S_PAY,
        S_CSUM
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   base_q, base_d;
    logic [AW-1:0]   len_q, len_d;
    logic [AW-1:0]   issued_q, issued_d;
    logic [AW-1:0]   pay_cnt_q, pay_cnt_d;
    logic [1:0]      hdr_idx_q, hdr_idx_d;
    logic [DW-1:0]   chk_q, chk_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            tx_valid_q, tx_valid_d;
    logic            tx_last_q, tx_last_d;
    logic [DW-1:0]   tx_data_q, tx_data_d;
    logic [RD_LAT-1:0] vld_sr_q, vld_sr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   fifo_cnt_q, fifo_cnt_d;
    logic [DW-1:0]   fifo_mem [FIFO_D];

    logic            xfer_c;
    logic            push_c;
    logic            pop_c;
    logic            rd_ce_c;
    logic            fifo_ne_c;
    int              inflight_c;

    // Header byte for a given position; length is sent big-endian as 16 bits.
    function automatic logic [DW-1:0] hdr_byte(input logic [1:0] idx, input logic [AW-1:0] len);
        logic [15:0] len16;
        len16 = 16'(len);
        case (idx)
            2'd0:    hdr_byte = 8'hA5;
            2'd1:    hdr_byte = 8'h5A;
            2'd2:    hdr_byte = len16[15:8];
            default: hdr_byte = len16[7:0];
        endcase
    endfunction

    assign busy     = busy_q;
    assign done     = done_q;
    assign rd_oce   = 1'b1;
    assign rd_ce    = rd_ce_c;
    assign rd_addr  = base_q + issued_q;
    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign tx_last  = tx_last_q;

    // Next-state logic: framing FSM, read issue with credit check, FIFO bookkeeping.
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        len_d      = len_q;
        issued_d   = issued_q;
        pay_cnt_d  = pay_cnt_q;
        hdr_idx_d  = hdr_idx_q;
        chk_d      = chk_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        tx_valid_d = tx_valid_q;
        tx_last_d  = tx_last_q;
        tx_data_d  = tx_data_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        pop_c      = 1'b0;
        inflight_c = 0;

        xfer_c    = tx_valid_q & tx_ready;
        push_c    = vld_sr_q[RD_LAT-1];
        fifo_ne_c = (fifo_cnt_q != '0);

        for (int i = 0; i < RD_LAT; i++) begin
            inflight_c = inflight_c + int'(vld_sr_q[i]);
        end

        // Reads run through header and payload; the credit limit keeps the
        // FIFO from ever receiving more data than it can hold.
        rd_ce_c = ((state_q == S_HDR) || (state_q == S_PAY)) &&
                  (issued_q < len_q) &&
                  ((int'(fifo_cnt_q) + inflight_c) < FIFO_D);
        if (rd_ce_c) begin
            issued_d = issued_q + AW'(1);
        end

        vld_sr_d[0] = rd_ce_c;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_sr_d[i] = vld_sr_q[i-1];
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d     = base_addr;
                    len_d      = frame_len;
                    issued_d   = '0;
                    pay_cnt_d  = '0;
                    hdr_idx_d  = 2'd0;
                    chk_d      = '0;
                    busy_d     = 1'b1;
                    tx_valid_d = 1'b1;
                    tx_last_d  = 1'b0;
                    tx_data_d  = hdr_byte(2'd0, frame_len);
                    state_d    = S_HDR;
                end
            end
            S_HDR: begin
                if (xfer_c) begin
                    if (hdr_idx_q != 2'd3) begin
                        hdr_idx_d = hdr_idx_q + 2'd1;
                        tx_data_d = hdr_byte(hdr_idx_q + 2'd1, len_q);
                    end else if (len_q == '0) begin
                        tx_data_d = chk_q;
                        tx_last_d = 1'b1;
                        state_d   = S_CSUM;
                    end else begin
                        state_d = S_PAY;
                        if (fifo_ne_c) begin
                            pop_c     = 1'b1;
                            tx_data_d = fifo_mem[rd_ptr_q];
                        end else begin
                            tx_valid_d = 1'b0;
                        end
                    end
                end
            end
            S_PAY: begin
                if (xfer_c) begin
                    chk_d     = chk_q + tx_data_q;
                    pay_cnt_d = pay_cnt_q + AW'(1);
                    if ((pay_cnt_q + AW'(1)) == len_q) begin
                        // Last payload byte leaves: the checksum follows directly.
                        tx_data_d = chk_q + tx_data_q;
                        tx_last_d = 1'b1;
                        state_d   = S_CSUM;
                    end else if (fifo_ne_c) begin
                        pop_c     = 1'b1;
                        tx_data_d = fifo_mem[rd_ptr_q];
                    end else begin
                        tx_valid_d = 1'b0;
                    end
                end else if (!tx_valid_q && fifo_ne_c) begin
                    pop_c      = 1'b1;
                    tx_valid_d = 1'b1;
                    tx_data_d  = fifo_mem[rd_ptr_q];
                end
            end
            S_CSUM: begin
                if (xfer_c) begin
                    tx_valid_d = 1'b0;
                    tx_last_d  = 1'b0;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (push_c) begin
            wr_ptr_d = (wr_ptr_q == PW'(FIFO_D - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop_c) begin
            rd_ptr_d = (rd_ptr_q == PW'(FIFO_D - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
        case ({push_c, pop_c})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CW'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CW'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    // State register; reset abandons any frame and drops reads still in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            pay_cnt_q  <= '0;
            hdr_idx_q  <= 2'd0;
            chk_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_last_q  <= 1'b0;
            tx_data_q  <= '0;
            vld_sr_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            pay_cnt_q  <= pay_cnt_d;
            hdr_idx_q  <= hdr_idx_d;
            chk_q      <= chk_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            tx_valid_q <= tx_valid_d;
            tx_last_q  <= tx_last_d;
            tx_data_q  <= tx_data_d;
            vld_sr_q   <= vld_sr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    // Skid FIFO storage; holds data only, so it carries no reset.
    always_ff @(posedge clk) begin
        if (push_c) begin
            fifo_mem[wr_ptr_q] <= rd_data;
        end
    end

    // The credit limit makes a write into a full FIFO impossible.
    assert property (@(posedge clk) disable iff (reset)
                     !(push_c && (fifo_cnt_q == CW'(FIFO_D))));

endmodule

// File: tb/tb_ad2tx_framer.sv
// Self-checking bench for ad2tx_framer with a behavioural buffer model and a
// frame-level reference model.
module tb_ad2tx_framer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [10:0] base_addr;
    logic [10:0] frame_len;
    logic        busy;
    logic        done;
    logic        rd_ce;
    logic        rd_oce;
    logic [10:0] rd_addr;
    logic [7:0]  rd_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_last;

    ad2tx_framer #(.AW(11), .DW(8), .RD_LAT(2), .FIFO_D(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .frame_len (frame_len),
        .busy      (busy),
        .done      (done),
        .rd_ce     (rd_ce),
        .rd_oce    (rd_oce),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_last   (tx_last)
    );

    int checks = 0;
    int failures = 0;

    logic [7:0] ram [0:2047];
    logic [7:0] rd_p1;

    int  exp_q[$];
    int  addr_q[$];
    bit  model_busy = 0;
    bit  done_next = 0;
    bit  stall_prev = 0;
    logic [7:0] held = 8'h00;
    int  rdce_cnt = 0;
    int  frame_xfers = 0;
    int  cyc = 0;
    int  first_cyc = 0;
    int  last_cyc = 0;
    bit  ready_mode = 0;
    bit  ok;
    int  lit1 [8];
    int  b;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pipelined buffer model: data two cycles after a read, junk otherwise.
    always @(posedge clk) begin
        rd_p1   <= rd_ce ? ram[rd_addr] : 8'($urandom);
        rd_data <= rd_p1;
    end

    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            tx_ready = ready_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // i-th byte of a frame, computed straight from the frame format.
    function automatic int frame_byte(input int base, input int len, input int i);
        int sum;
        if (i == 0) return 'hA5;
        if (i == 1) return 'h5A;
        if (i == 2) return (len >> 8) & 'hFF;
        if (i == 3) return len & 'hFF;
        if (i < 4 + len) return int'(ram[(base + i - 4) % 2048]);
        sum = 0;
        for (int k = 0; k < len; k++) sum += int'(ram[(base + k) % 2048]);
        return sum % 256;
    endfunction

    task automatic model_frame(input int base, input int len);
        for (int i = 0; i < len + 5; i++) exp_q.push_back(frame_byte(base, len, i));
        for (int i = 0; i < len; i++) addr_q.push_back((base + i) % 2048);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_busy"},     busy,     0);
        chk({tag, "_done"},     done,     0);
        chk({tag, "_rd_ce"},    rd_ce,    0);
        chk({tag, "_rd_oce"},   rd_oce,   1);
        chk({tag, "_rd_addr"},  rd_addr,  0);
        chk({tag, "_tx_valid"}, tx_valid, 0);
        chk({tag, "_tx_last"},  tx_last,  0);
        chk({tag, "_tx_data"},  tx_data,  0);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #2 reset = 1'b1;
        @(posedge clk); #2 reset = 1'b0;
    endtask

    // Per-cycle comparison of the DUT against the frame model.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            addr_q.delete();
            model_busy = 0;
            done_next  = 0;
            stall_prev = 0;
        end else begin
            cyc++;
            chk("done", done, int'(done_next));
            done_next = 0;
            chk("busy", busy, int'(model_busy));
            if (rd_ce) begin
                rdce_cnt++;
                if (addr_q.size() == 0) chk("rd_ce_extra", 1, 0);
                else begin
                    chk("rd_addr", rd_addr, addr_q[0]);
                    addr_q.delete(0);
                end
            end
            if (stall_prev) begin
                chk("stall_valid", tx_valid, 1);
                chk("stall_data", tx_data, held);
            end
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) chk("xfer_extra", 1, 0);
                else begin
                    chk("tx_data", tx_data, exp_q[0]);
                    chk("tx_last", tx_last, int'(exp_q.size() == 1));
                    exp_q.delete(0);
                    if (frame_xfers == 0) first_cyc = cyc;
                    last_cyc = cyc;
                    frame_xfers++;
                    if (exp_q.size() == 0) begin
                        done_next  = 1;
                        model_busy = 0;
                    end
                end
            end
            stall_prev = tx_valid && !tx_ready;
            held = tx_data;
            if (start && !model_busy) model_busy = 1;
        end
    end

    task automatic run_frame(input int base, input int len, input bit extra_start, input int exp_span);
        bit finished;
        @(posedge clk); #2;
        rdce_cnt = 0;
        frame_xfers = 0;
        model_frame(base, len);
        base_addr = 11'(base);
        frame_len = 11'(len);
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        if (extra_start) begin
            @(posedge clk); #2;
            base_addr = 11'($urandom);
            frame_len = 11'($urandom_range(1, 2047));
            start = 1'b1;
            @(posedge clk); #2;
            start = 1'b0;
        end
        finished = 0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (!model_busy) begin
                finished = 1;
                break;
            end
        end
        chk("frame_complete", finished, 1);
        if (!finished) pulse_reset();
        @(negedge clk);
        chk("rd_ce_count", rdce_cnt, len);
        chk("xfer_count", frame_xfers, len + 5);
        chk("idle_valid", tx_valid, 0);
        if (exp_span >= 0) chk("span", last_cyc - first_cyc, exp_span);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        base_addr = '0;
        frame_len = '0;
        for (int i = 0; i < 2048; i++) ram[i] = 8'($urandom);
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        check_reset_vals("init");

        // T1
        ram[16] = 8'h01; ram[17] = 8'h02; ram[18] = 8'h03;
        lit1 = '{'hA5, 'h5A, 'h00, 'h03, 'h01, 'h02, 'h03, 'h06};
        for (int k = 0; k < 8; k++) chk("t1_model", frame_byte(16, 3, k), lit1[k]);
        run_frame(16, 3, 0, 7);

        // T2
        ram[2046] = 8'hFF; ram[2047] = 8'h01; ram[0] = 8'h10; ram[1] = 8'h20;
        chk("t2_model_chk", frame_byte(2046, 4, 8), 'h30);
        run_frame(2046, 4, 0, 8);

        // T5: empty payload, plus a start pulse while busy
        chk("t5_model_chk", frame_byte(100, 0, 4), 0);
        run_frame($urandom_range(0, 2047), 0, 1, 4);

        // T3: maximum length, back-to-back
        run_frame($urandom_range(0, 2047), 2047, 0, 2051);

        // T4: random backpressure
        ready_mode = 1;
        run_frame($urandom_range(0, 2047), 16, 0, -1);
        for (int n = 0; n < 4; n++) run_frame($urandom_range(0, 2047), $urandom_range(1, 60), 0, -1);
        run_frame(2040, 20, 0, -1);

        // T6: reset in the middle of the payload
        ready_mode = 0;
        b = $urandom_range(0, 2047);
        @(posedge clk); #2;
        rdce_cnt = 0;
        frame_xfers = 0;
        model_frame(b, 32);
        base_addr = 11'(b);
        frame_len = 11'd32;
        start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (frame_xfers >= 9) begin
                ok = 1;
                break;
            end
        end
        chk("t6_reach_payload", ok, 1);
        pulse_reset();
        @(negedge clk);
        check_reset_vals("t6");
        run_frame($urandom_range(0, 2047), 32, 0, 36);
        ready_mode = 1;
        run_frame($urandom_range(0, 2047), 32, 0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
